regfile_mp: RTL and testbench

//  Parametrised multi-port general register file for the GeMIPS ID stage.
//  - NRD combinational read ports and two synchronous write ports (WB and a second retire path).
//  - Same-cycle write->read bypass; register 0 hardwired to zero.
//  - Sequential post-reset clear engine with a ready flag.
//  - Optional per-register busy scoreboard.

---
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GeMIPS register file with write->read bypass and post-reset clear.
// Define GEMIPS_RF_SCOREBOARD_EN to add the per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  issue_we,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic [NRD-1:0]        rbusy
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                run;
    assign run = state == RUN;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == '1) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end
    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) mem[ptr] <= '0;
            else begin
                if (we0 && waddr0 != '0) mem[waddr0] <= wdata0;
                if (we1 && waddr1 != '0) mem[waddr1] <= wdata1;
            end
        end
    end
`ifdef GEMIPS_RF_SCOREBOARD_EN
    logic [DEPTH-1:0] busy, busy_clr, busy_set;
    assign busy_clr = ({DEPTH{we0}} & (DEPTH'(1) << waddr0)) | ({DEPTH{we1}} & (DEPTH'(1) << waddr1));
    assign busy_set = {DEPTH{issue_we}} & (DEPTH'(1) << issue_addr);
    // Set after clear: a newly issued producer outranks the retiring one; bit 0 never sticks.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else if (run) busy <= ((busy & ~busy_clr) | busy_set) & ~DEPTH'(1);
    end
`else
    logic unused_issue;
    assign unused_issue = ^{issue_we, issue_addr};
`endif
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];
        assign rdata[i*DATA_W +: DATA_W] =
            (!run || !re[i] || ra == '0) ? '0 :
            (we1 && waddr1 == ra)        ? wdata1 :
            (we0 && waddr0 == ra)        ? wdata0 : mem[ra];
`ifdef GEMIPS_RF_SCOREBOARD_EN
        assign rbusy[i] = run && re[i] && busy[ra];
`else
        assign rbusy[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NRD = 2, DEPTH = 32;
`ifdef GEMIPS_RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    logic clk = 1'b0, rst, ready, we0, we1, issue_we;
    logic [AW-1:0] waddr0, waddr1, issue_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic [NRD-1:0] re, rbusy;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    int checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    bit ref_busy [DEPTH];
    bit ref_ready = 1'b0;
    int clr_cnt = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata),
        .issue_we(issue_we), .issue_addr(issue_addr), .rbusy(rbusy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(int i);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        if (!ref_ready || !re[i] || a == 0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(int i);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        return SB && ref_ready && re[i] && ref_busy[a];
    endfunction

    task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour at a clock edge, from the architectural rules.
    task automatic model_edge();
        if (rst) begin
            clr_cnt = 0;
            ref_ready = 1'b0;
            foreach (ref_busy[k]) ref_busy[k] = 1'b0;
        end else if (!ref_ready) begin
            clr_cnt++;
            if (clr_cnt == DEPTH) begin
                ref_ready = 1'b1;
                foreach (ref_mem[k]) ref_mem[k] = '0;
            end
        end else begin
            if (we0 && waddr0 != 0) ref_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 0) ref_mem[waddr1] = wdata1;
            if (we0) ref_busy[waddr0] = 1'b0;
            if (we1) ref_busy[waddr1] = 1'b0;
            if (issue_we && issue_addr != 0) ref_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(string tag);
        #1;
        chk({tag, ".ready"}, DW'(ready), DW'(ref_ready));
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("%s.rdata%0d", tag, i), rdata[i*DW +: DW], exp_rd(i));
            chk($sformatf("%s.rbusy%0d", tag, i), DW'(rbusy[i]), DW'(exp_busy(i)));
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; issue_we = 0; re = '0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_addr = '0; raddr = '0;
    endtask

    task automatic rd(int a0, int a1);
        re = 2'b11;
        raddr = {AW'(a1), AW'(a0)};
    endtask

    function automatic logic [AW-1:0] raddr_pick();
        return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
    endfunction

    task automatic randomize_inputs();
        we0 = 1'($urandom); we1 = 1'($urandom); issue_we = 1'($urandom);
        waddr0 = raddr_pick(); waddr1 = raddr_pick(); issue_addr = raddr_pick();
        wdata0 = $urandom; wdata1 = $urandom;
        re = NRD'($urandom);
        raddr = {raddr_pick(), raddr_pick()};
    endtask

    task automatic wait_ready(string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            randomize_inputs();
            check(tag);
        end
        chk({tag, ".cycles"}, DW'(n), DW'(DEPTH));
        idle();
    endtask

    initial begin
        foreach (ref_mem[k]) ref_mem[k] = '0;
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        check("reset");
        rst = 0;
        wait_ready("clear0");

        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; rd(5, 0);
        check("w5_bypass");
        tick(); idle(); rd(5, 0);
        check("r5");
        chk("r5_direct", rdata[DW-1:0], 32'hDEADBEEF);

        we0 = 1; waddr0 = 0; wdata0 = 32'h1; rd(0, 0);
        check("w0_same");
        tick(); idle(); rd(0, 5);
        check("r0");
        chk("r0_direct", rdata[DW-1:0], 32'h0);

        we0 = 1; waddr0 = 7; wdata0 = 32'hA; we1 = 1; waddr1 = 7; wdata1 = 32'hB; rd(7, 7);
        check("prio_bypass");
        chk("prio_direct", rdata[2*DW-1:DW], 32'hB);
        tick(); idle(); rd(7, 0);
        check("prio_entry");
        chk("prio_entry_direct", rdata[DW-1:0], 32'hB);

        issue_we = 1; issue_addr = 9;
        tick(); idle(); rd(9, 0);
        check("sb_issue");
        chk("sb_issue_direct", DW'(rbusy[0]), DW'(SB));
        we0 = 1; waddr0 = 9; wdata0 = 32'h99; issue_we = 1; issue_addr = 9; rd(9, 9);
        check("sb_both");
        tick(); idle(); rd(9, 0);
        check("sb_still");
        chk("sb_still_direct", DW'(rbusy[0]), DW'(SB));
        we0 = 1; waddr0 = 9; wdata0 = 32'h77;
        tick(); idle(); rd(9, 0);
        check("sb_clear");
        chk("sb_clear_direct", DW'(rbusy[0]), 32'h0);
        chk("sb_data_direct", rdata[DW-1:0], 32'h77);

        for (int a = 1; a < DEPTH; a++) begin
            we0 = 1; waddr0 = AW'(a); wdata0 = $urandom | 32'h1;
            tick();
        end
        idle();
        rst = 1;
        tick();
        rst = 0;
        check("garbage_rst");
        wait_ready("clear1");
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, DEPTH - 1 - a);
            check("cleared");
            chk("cleared_direct", rdata[DW-1:0], 32'h0);
        end
        idle();

        rst = 1;
        tick();
        rst = 0;
        repeat (10) tick();
        check("mid_clear");
        rst = 1;
        tick();
        rst = 0;
        wait_ready("clear2");

        repeat (400) begin
            randomize_inputs();
            check("rand");
            tick();
        end
        idle();
        check("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
